// File: rtl/varz_circular_shifter.sv
// Variable-Z cyclic rotator: a doubled vector is built in stage 0, then NST
// stages each resolve ROTATES_PER_CYCLE shift bit-levels, with one shared stall.

module varz_cs_stage #(
   parameter int MAXZ = 81,
   parameter int SW   = 7,
   parameter int LO   = 0,
   parameter int HI   = 1,
   parameter int OW   = 2*MAXZ
) (
   input  logic [2*MAXZ-1:0] dat_i,
   input  logic [SW-1:0]     sh_i,
   output logic [OW-1:0]     dat_o
);
   logic [2*MAXZ-1:0] d;

   // Right-shifting the doubled vector by s yields the rotated word in its low z bits.
   always_comb begin
      d = dat_i;
      for (int j = 0; j < SW; j++)
         if (j >= LO && j < HI && sh_i[j]) d = d >> (1 << j);
      dat_o = d[OW-1:0];
   end
endmodule

module varz_circular_shifter #(
   parameter  int MAXZ              = 81,
   parameter  int ROTATES_PER_CYCLE = 2,
   parameter  int TAGW              = 8,
   localparam int SW                = $clog2(MAXZ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [MAXZ-1:0] in_data,
   input  logic [SW:0]     z_in,
   input  logic [SW-1:0]   shift_val,
   input  logic            dir,
   input  logic [TAGW-1:0] tag_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [MAXZ-1:0] out_data,
   output logic [TAGW-1:0] tag_out,
   output logic            err_out,
   output logic [15:0]     err_cnt
);
   localparam int NST = (SW + ROTATES_PER_CYCLE - 1) / ROTATES_PER_CYCLE;
   localparam int LAT = NST + 1;
   localparam logic [SW:0] MAXZ_Z = (SW+1)'(MAXZ);

   logic                          adv;
   logic [LAT-1:0]                vld_pipe;
   logic [NST-1:0][2*MAXZ-1:0]    p_dat;
   logic [NST-1:0][SW-1:0]        p_sh;
   logic [NST-1:0][SW:0]          p_z;
   logic [LAT-1:0][TAGW-1:0]      p_tag;
   logic [LAT-1:0]                p_err;
   logic [NST-1:0][2*MAXZ-1:0]    nxt_dat;
   logic [MAXZ-1:0]               lst_rot;
   logic [MAXZ-1:0]               lst_dat;

   logic                          illegal;
   logic [SW:0]                   zeff;
   logic [2*MAXZ-1:0]             mx;
   logic [2*MAXZ-1:0]             dbl0;
   logic [SW-1:0]                 sh0;

   function automatic logic [MAXZ-1:0] zmask(input logic [SW:0] z);
      logic [MAXZ-1:0] m;
      for (int i = 0; i < MAXZ; i++) m[i] = (i < int'(z));
      return m;
   endfunction

   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[LAT-1];
   assign tag_out   = p_tag[LAT-1];
   assign err_out   = p_err[LAT-1];

   // Left rotation is folded into an equivalent right rotation; illegal items pass unrotated.
   always_comb begin
      illegal = (z_in == '0) || (z_in > MAXZ_Z) || ({1'b0, shift_val} >= z_in);
      zeff    = (z_in > MAXZ_Z) ? MAXZ_Z : z_in;
      mx      = {{MAXZ{1'b0}}, in_data & zmask(zeff)};
      if (illegal) begin
         dbl0 = mx;
         sh0  = '0;
      end else begin
         dbl0 = mx | (mx << z_in);
         sh0  = (dir && shift_val != '0) ? SW'(z_in - {1'b0, shift_val}) : shift_val;
      end
   end

   assign nxt_dat[0] = dbl0;

   for (genvar k = 1; k <= NST; k++) begin : g_st
      localparam int LO = (k-1) * ROTATES_PER_CYCLE;
      localparam int HI = (k * ROTATES_PER_CYCLE > SW) ? SW : k * ROTATES_PER_CYCLE;
      if (k < NST) begin : g_mid
         varz_cs_stage #(.MAXZ(MAXZ), .SW(SW), .LO(LO), .HI(HI), .OW(2*MAXZ)) u_stage (
            .dat_i(p_dat[k-1]),
            .sh_i (p_sh[k-1]),
            .dat_o(nxt_dat[k])
         );
      end else begin : g_last
         varz_cs_stage #(.MAXZ(MAXZ), .SW(SW), .LO(LO), .HI(HI), .OW(MAXZ)) u_stage (
            .dat_i(p_dat[k-1]),
            .sh_i (p_sh[k-1]),
            .dat_o(lst_rot)
         );
      end
   end

   assign lst_dat = lst_rot & zmask(p_z[NST-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         p_dat    <= '0;
         p_sh     <= '0;
         p_z      <= '0;
         p_tag    <= '0;
         p_err    <= '0;
         out_data <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
         p_tag    <= {p_tag[LAT-2:0], tag_in};
         p_err    <= {p_err[LAT-2:0], in_valid & illegal};
         p_dat[0] <= nxt_dat[0];
         p_sh[0]  <= sh0;
         p_z[0]   <= zeff;
         for (int k = 1; k < NST; k++) begin
            p_dat[k] <= nxt_dat[k];
            p_sh[k]  <= p_sh[k-1];
            p_z[k]   <= p_z[k-1];
         end
         out_data <= lst_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (out_valid && out_ready && err_out && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end
endmodule
